// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-side bus interconnect.
package bus_pkg;

   // Transaction tracker states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2,
      ST_DONE = 2'd3
   } bus_state_e;

   // Access size encodings carried on m_size / s_size
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Data returned on an error response unless overridden
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // Latched request broadcast to every slave channel
   typedef struct packed {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] wdata;
      logic [1:0]  size;
   } bus_req_t;

endpackage

// File: rtl/bus_interconnect_if.sv
// Master-side request/response bus plus the per-slave channels.
// slave modport: the interconnect's view. master modport: the surrounding
// system (CPU and slave devices) driving requests and slave responses.
interface bus_interconnect_if #(
   parameter int unsigned NSLAVES = 2
);
   logic [31:0]           m_address;
   logic                  m_rw_req;
   logic                  m_rw;
   logic [31:0]           m_write_data;
   logic [1:0]            m_size;
   logic [31:0]           m_read_data;
   logic                  m_rec;
   logic                  m_err;
   logic [NSLAVES-1:0]    s_rw_req;
   logic [31:0]           s_address;
   logic                  s_rw;
   logic [31:0]           s_write_data;
   logic [1:0]            s_size;
   logic [NSLAVES*32-1:0] s_read_data;
   logic [NSLAVES-1:0]    s_rec;

   modport slave (
      input  m_address, m_rw_req, m_rw, m_write_data, m_size,
      output m_read_data, m_rec, m_err,
      output s_rw_req, s_address, s_rw, s_write_data, s_size,
      input  s_read_data, s_rec
   );

   modport master (
      output m_address, m_rw_req, m_rw, m_write_data, m_size,
      input  m_read_data, m_rec, m_err,
      input  s_rw_req, s_address, s_rw, s_write_data, s_size,
      output s_read_data, s_rec
   );
endinterface

// File: rtl/bus_timeout_ctr.sv
// Cycle counter with clear/enable; expire_c flags the last allowed cycle.
module bus_timeout_ctr #(
   parameter int unsigned W     = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire_c
);
   logic [W-1:0] count_q, count_d;

   // Clear has priority over counting
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_c = (count_q == W'(LIMIT - 1));
endmodule

// File: rtl/bus_interconnect.sv
// Single-master to NSLAVES-channel bus decoder with one outstanding
// transaction, error response for unmapped addresses and silent slaves.
// NSLAVES must match the parameter of the connected interface.
module bus_interconnect
   import bus_pkg::*;
#(
   parameter int unsigned NSLAVES  = 2,
   parameter int unsigned SEL_W    = 1,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   bus_interconnect_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   bus_state_e         state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   bus_req_t           req_q, req_d;
   logic [NSLAVES-1:0] s_rw_req_q, s_rw_req_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rec_q, rec_d;
   logic               err_q, err_d;

   logic [SEL_W-1:0]   idx_c;
   logic               rec_sel_c;
   logic [31:0]        rdata_sel_c;
   logic               ctr_clr_c, ctr_en_c, ctr_exp_c;

   assign idx_c = bus.m_address[31 -: SEL_W];

   bus_timeout_ctr #(
      .W     (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr      (ctr_clr_c),
      .en       (ctr_en_c),
      .expire_c (ctr_exp_c)
   );

   // Pick the data-valid and read data of the selected channel only
   always_comb begin
      rec_sel_c   = 1'b0;
      rdata_sel_c = '0;
      for (int unsigned i = 0; i < NSLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            rec_sel_c   = bus.s_rec[i];
            rdata_sel_c = bus.s_read_data[i*32 +: 32];
         end
      end
   end

   // Next state and registered-output values
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      req_d      = req_q;
      s_rw_req_d = s_rw_req_q;
      rdata_d    = rdata_q;
      rec_d      = 1'b0;
      err_d      = 1'b0;
      ctr_clr_c  = 1'b0;
      ctr_en_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ctr_clr_c = 1'b1;
            if (bus.m_rw_req) begin
               req_d = '{addr:  bus.m_address,
                         rw:    bus.m_rw,
                         wdata: bus.m_write_data,
                         size:  bus.m_size};
               if (32'(idx_c) < NSLAVES) begin
                  sel_d      = idx_c;
                  s_rw_req_d = NSLAVES'(1) << idx_c;
                  state_d    = ST_WAIT;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_WAIT: begin
            ctr_en_c = 1'b1;
            if (!bus.m_rw_req) begin
               // master abort: drop the slave request without responding
               s_rw_req_d = '0;
               state_d    = ST_IDLE;
            end else if (rec_sel_c) begin
               // data beats the timeout when both land in the same cycle
               rdata_d    = rdata_sel_c;
               rec_d      = 1'b1;
               s_rw_req_d = '0;
               state_d    = ST_DONE;
            end else if (ctr_exp_c) begin
               s_rw_req_d = '0;
               state_d    = ST_ERR;
            end
         end
         ST_ERR: begin
            rec_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // wait for the master to release so a held request is not re-issued
            if (!bus.m_rw_req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         req_q      <= '0;
         s_rw_req_q <= '0;
         rdata_q    <= '0;
         rec_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         req_q      <= req_d;
         s_rw_req_q <= s_rw_req_d;
         rdata_q    <= rdata_d;
         rec_q      <= rec_d;
         err_q      <= err_d;
      end
   end

   assign bus.m_read_data  = rdata_q;
   assign bus.m_rec        = rec_q;
   assign bus.m_err        = err_q;
   assign bus.s_rw_req     = s_rw_req_q;
   assign bus.s_address    = req_q.addr;
   assign bus.s_rw         = req_q.rw;
   assign bus.s_write_data = req_q.wdata;
   assign bus.s_size       = req_q.size;
endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: two instances (2 slaves / 1 select bit and
// 3 slaves / 2 select bits), both with an 8-cycle timeout.
module tb_bus_interconnect;
   import bus_pkg::*;

   localparam int unsigned TO   = 8;
   localparam logic [31:0] DEAD = 32'hDEADBEEF;

   logic        clk, reset;
   logic        dsel;
   logic        m_req, m_rw;
   logic [31:0] m_addr, m_wdata;
   logic [1:0]  m_size;
   logic [2:0]  rec_v;
   logic [95:0] rdata_v;
   int          total = 0;
   int          bad   = 0;

   bus_interconnect_if #(.NSLAVES(2)) bif_a ();
   bus_interconnect_if #(.NSLAVES(3)) bif_b ();

   bus_interconnect #(.NSLAVES(2), .SEL_W(1), .TIMEOUT(TO), .ERR_DATA(DEAD))
      dut_a (.clk(clk), .reset(reset), .bus(bif_a));
   bus_interconnect #(.NSLAVES(3), .SEL_W(2), .TIMEOUT(TO), .ERR_DATA(DEAD))
      dut_b (.clk(clk), .reset(reset), .bus(bif_b));

   assign bif_a.m_address    = m_addr;
   assign bif_a.m_rw         = m_rw;
   assign bif_a.m_write_data = m_wdata;
   assign bif_a.m_size       = m_size;
   assign bif_a.m_rw_req     = m_req & ~dsel;
   assign bif_a.s_rec        = dsel ? 2'b00 : rec_v[1:0];
   assign bif_a.s_read_data  = rdata_v[63:0];
   assign bif_b.m_address    = m_addr;
   assign bif_b.m_rw         = m_rw;
   assign bif_b.m_write_data = m_wdata;
   assign bif_b.m_size       = m_size;
   assign bif_b.m_rw_req     = m_req & dsel;
   assign bif_b.s_rec        = dsel ? rec_v : 3'b000;
   assign bif_b.s_read_data  = rdata_v;

   logic [2:0]  o_sreq;
   logic        o_rec, o_err;
   logic [31:0] o_rdata;
   logic [66:0] o_bc;

   always_comb begin
      if (dsel) begin
         o_sreq  = bif_b.s_rw_req;
         o_rec   = bif_b.m_rec;
         o_err   = bif_b.m_err;
         o_rdata = bif_b.m_read_data;
         o_bc    = {bif_b.s_address, bif_b.s_rw, bif_b.s_write_data, bif_b.s_size};
      end else begin
         o_sreq  = {1'b0, bif_a.s_rw_req};
         o_rec   = bif_a.m_rec;
         o_err   = bif_a.m_err;
         o_rdata = bif_a.m_read_data;
         o_bc    = {bif_a.s_address, bif_a.s_rw, bif_a.s_write_data, bif_a.s_size};
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          d;
      logic [31:0] addr;
      logic        rw;
      logic [31:0] wdata;
      logic [1:0]  size;
      int          lat;       // cycles after s_rw_req rises; -1 = silent slave
      logic [31:0] sdata;
      bit          stray;
      logic [2:0]  exp_sreq;
      int          exp_rc;    // cycle of m_rec, request sampled at cycle 0
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic [2:0]  sreq;
      int          rise;
      int          rec_cyc;
      int          rec_cnt;
      logic        err;
      logic [31:0] rdata;
      int          glitch;
      logic [66:0] bc;
   } res_t;

   vec_t tbl [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decode, slave latency vs timeout window, error data
   function automatic void model(input bit d, input logic [31:0] addr, input int lat,
                                 input logic [31:0] sdata, output logic [2:0] sreq,
                                 output int rc, output logic err, output logic [31:0] rd);
      int unsigned n   = d ? 3 : 2;
      int unsigned sw  = d ? 2 : 1;
      int unsigned idx = addr >> (32 - sw);
      if (idx >= n) begin
         sreq = 3'b000; rc = 2; err = 1'b1; rd = DEAD;
      end else begin
         sreq = 3'(1 << idx);
         if (lat >= 0 && lat < int'(TO)) begin
            rc = lat + 2; err = 1'b0; rd = sdata;
         end else begin
            rc = int'(TO) + 2; err = 1'b1; rd = DEAD;
         end
      end
   endfunction

   // Issue one request, play the slave, observe 16 cycles with request held
   task automatic run_txn(input bit d, input logic [31:0] addr, input logic rw,
                          input logic [31:0] wdata, input logic [1:0] size, input int lat,
                          input logic [31:0] sdata, input bit stray, output res_t r);
      int j = 0;
      int n = d ? 3 : 2;
      logic [2:0] prev = 3'b000;
      r.sreq = 3'b000; r.rise = 0; r.rec_cyc = 0; r.rec_cnt = 0;
      r.err = 1'b0; r.rdata = '0; r.glitch = 0; r.bc = '0;
      dsel = d; m_addr = addr; m_rw = rw; m_wdata = wdata; m_size = size;
      rec_v = 3'b000; rdata_v = '0; m_req = 1'b1;
      tick();
      for (int c = 1; c <= 16; c++) begin
         if (o_sreq != 3'b000 && r.rise == 0) begin
            r.rise = c; r.sreq = o_sreq; r.bc = o_bc;
            for (int k = 0; k < 3; k++) if (o_sreq[k]) j = k;
         end else if (o_sreq != 3'b000 && prev == 3'b000) begin
            r.glitch++;
         end
         if (o_sreq != 3'b000 && o_bc != r.bc) r.glitch++;
         if ($countones(o_sreq) > 1) r.glitch++;
         if (o_err && !o_rec) r.glitch++;
         if (o_rec) begin
            r.rec_cnt++;
            if (r.rec_cnt == 1) begin
               r.rec_cyc = c; r.err = o_err; r.rdata = o_rdata;
            end
         end
         prev = o_sreq;
         rec_v = 3'b000;
         rdata_v = {$urandom, $urandom, $urandom};
         if (r.rise != 0) begin
            if (stray && o_sreq != 3'b000) begin
               int k = (j + 1) % n;
               rec_v[k] = 1'b1;
            end
            if (lat >= 0 && c == r.rise + lat) begin
               rec_v[j] = 1'b1;
               rdata_v[j*32 +: 32] = sdata;
            end
         end
         tick();
      end
      m_req = 1'b0; rec_v = 3'b000;
      repeat (3) tick();
   endtask

   task automatic compare(input string tag, input vec_t v, input logic [2:0] es, input int erc,
                          input logic ee, input logic [31:0] erd, input res_t r);
      check({tag, ".sreq"},    96'(r.sreq),    96'(es));
      check({tag, ".rec_cyc"}, 96'(r.rec_cyc), 96'(erc));
      check({tag, ".rec_cnt"}, 96'(r.rec_cnt), 96'(1));
      check({tag, ".err"},     96'(r.err),     96'(ee));
      check({tag, ".rdata"},   96'(r.rdata),   96'(erd));
      check({tag, ".glitch"},  96'(r.glitch),  96'(0));
      if (es != 3'b000) begin
         check({tag, ".rise"}, 96'(r.rise), 96'(1));
         check({tag, ".bcast"}, 96'(r.bc), 96'({v.addr, v.rw, v.wdata, v.size}));
      end
   endtask

   initial begin
      res_t r;
      int   cnt;
      logic [2:0]  es;
      int          erc;
      logic        ee;
      logic [31:0] erd;
      vec_t        v;

      tbl[0] = '{0, 32'h00000010, 0, 32'h0,        SZ_WORD, 3, 32'h12345678, 0, 3'b001, 5,  0, 32'h12345678};
      tbl[1] = '{0, 32'h80000004, 1, 32'hA5A5A5A5, SZ_WORD, 2, 32'h0000C0DE, 0, 3'b010, 4,  0, 32'h0000C0DE};
      tbl[2] = '{1, 32'hC0000000, 0, 32'h0,        SZ_BYTE, 1, 32'h11111111, 0, 3'b000, 2,  1, DEAD};
      tbl[3] = '{0, 32'h00000100, 0, 32'h0,        SZ_HALF, -1, 32'h0,       0, 3'b001, 10, 1, DEAD};
      tbl[4] = '{0, 32'h00000200, 0, 32'h0,        SZ_WORD, 7, 32'hCAFEF00D, 0, 3'b001, 9,  0, 32'hCAFEF00D};
      tbl[5] = '{0, 32'h00000300, 0, 32'h0,        SZ_WORD, 2, 32'h0BADBEEF, 1, 3'b001, 4,  0, 32'h0BADBEEF};
      tbl[6] = '{1, 32'h80000000, 0, 32'h0,        SZ_WORD, 1, 32'h22223333, 1, 3'b100, 3,  0, 32'h22223333};
      tbl[7] = '{1, 32'h40000008, 1, 32'h5A5A0001, SZ_BYTE, 0, 32'h44445555, 0, 3'b010, 2,  0, 32'h44445555};
      tbl[8] = '{0, 32'h80000000, 0, 32'h0,        SZ_WORD, 8, 32'h66667777, 0, 3'b010, 10, 1, DEAD};

      reset = 1'b0; dsel = 1'b0; m_req = 1'b0; m_rw = 1'b0; m_addr = '0;
      m_wdata = '0; m_size = '0; rec_v = '0; rdata_v = '0;
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         #1;
         check($sformatf("reset%0d.sreq", d),  96'(o_sreq),  96'(0));
         check($sformatf("reset%0d.rec", d),   96'(o_rec),   96'(0));
         check($sformatf("reset%0d.err", d),   96'(o_err),   96'(0));
         check($sformatf("reset%0d.rdata", d), 96'(o_rdata), 96'(0));
         check($sformatf("reset%0d.bcast", d), 96'(o_bc),    96'(0));
      end
      dsel = 1'b0;
      reset = 1'b1;
      tick();

      foreach (tbl[i]) begin
         v = tbl[i];
         run_txn(v.d, v.addr, v.rw, v.wdata, v.size, v.lat, v.sdata, v.stray, r);
         compare($sformatf("vec%0d", i), v, v.exp_sreq, v.exp_rc, v.exp_err, v.exp_rd, r);
      end

      // master abort in WAIT: request dropped, no response ever
      dsel = 1'b0; m_addr = 32'h00000020; m_rw = 1'b0; m_req = 1'b1;
      tick();
      check("abort.pre_sreq", 96'(o_sreq), 96'(3'b001));
      tick();
      m_req = 1'b0;
      tick();
      check("abort.sreq", 96'(o_sreq), 96'(0));
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (o_rec || o_sreq != 3'b000) cnt++;
         tick();
      end
      check("abort.quiet", 96'(cnt), 96'(0));

      // asynchronous reset in WAIT, then a fresh transaction
      m_addr = 32'h00000040; m_req = 1'b1;
      repeat (3) tick();
      check("rstwait.pre_sreq", 96'(o_sreq), 96'(3'b001));
      reset = 1'b0;
      #1;
      check("rstwait.sreq",  96'(o_sreq),  96'(0));
      check("rstwait.rec",   96'(o_rec),   96'(0));
      check("rstwait.rdata", 96'(o_rdata), 96'(0));
      check("rstwait.bcast", 96'(o_bc),    96'(0));
      m_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      v = tbl[0];
      run_txn(v.d, v.addr, v.rw, v.wdata, v.size, v.lat, v.sdata, v.stray, r);
      compare("rstwait.after", v, v.exp_sreq, v.exp_rc, v.exp_err, v.exp_rd, r);

      // randomized transactions against the reference model
      for (int i = 0; i < 60; i++) begin
         int rl;
         v.d     = $urandom_range(0, 1) == 1;
         v.addr  = $urandom;
         v.rw    = $urandom_range(0, 1) == 1;
         v.wdata = $urandom;
         v.size  = 2'($urandom_range(0, 2));
         rl      = int'($urandom_range(0, 11));
         v.lat   = (rl == 11) ? -1 : rl;
         v.sdata = $urandom;
         v.stray = $urandom_range(0, 1) == 1;
         model(v.d, v.addr, v.lat, v.sdata, es, erc, ee, erd);
         run_txn(v.d, v.addr, v.rw, v.wdata, v.size, v.lat, v.sdata, v.stray, r);
         compare($sformatf("rnd%0d", i), v, es, erc, ee, erd, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
